// File: rtl/atm_account_responder_if.sv
// Request/response bundle between the ATM session controller (master)
// and the account responder (slave).
interface atm_account_responder_if #(
   parameter int BAL_W = 16
);
   logic [4:0]       action;
   logic             action_valid;
   logic [3:0]       InPass;
   logic [BAL_W-1:0] amount;
   logic             cnl;
   logic             busy;
   logic             done;
   logic             pass_ok;
   logic             pass_bad;
   logic             vb;
   logic             ai;
   logic             err_auth;
   logic             dispense;
   logic             locked;
   logic [BAL_W-1:0] balance;
   logic [1:0]       tries;

   modport master (
      output action, action_valid, InPass, amount, cnl,
      input  busy, done, pass_ok, pass_bad, vb, ai, err_auth,
             dispense, locked, balance, tries
   );

   modport slave (
      input  action, action_valid, InPass, amount, cnl,
      output busy, done, pass_ok, pass_bad, vb, ai, err_auth,
             dispense, locked, balance, tries
   );
endinterface

// File: rtl/atm_account_responder.sv
// Account-side responder: PIN check with lockout, balance / deposit /
// withdraw on one account register, and one-note-per-cycle dispensing
// with cancel refund.
// Optional macro DAILY_LIMIT_EN adds a cumulative withdrawn-total limit.
module atm_account_responder #(
   parameter logic [3:0] PASSWORD  = 4'b1111,
   parameter int         BAL_W     = 16,
   parameter int         INIT_BAL  = 1000,
   parameter int         NOTE_VAL  = 10,
   parameter int         MAX_WD    = 500,
   parameter int         MAX_TRIES = 3,
   parameter int         DAILY_LIM = 800
) (
   input logic                    clk,
   input logic                    rst,
   atm_account_responder_if.slave bus
);

   localparam logic [4:0] A_END      = 5'd1;
   localparam logic [4:0] A_PASS     = 5'd4;
   localparam logic [4:0] A_BALANCE  = 5'd8;
   localparam logic [4:0] A_DEPOSIT  = 5'd10;
   localparam logic [4:0] A_WITHDRAW = 5'd13;

   localparam int CNT_W = $clog2(MAX_WD / NOTE_VAL + 1);

   typedef enum logic [2:0] {
      IDLE, EXEC, DISPENSE, DONE, LOCK
   } state_t;

   state_t           state;
   logic [4:0]       act_q;
   logic [3:0]       pass_q;
   logic [BAL_W-1:0] amt_q;
   logic [BAL_W-1:0] bal_q;
   logic [1:0]       tries_q;
   logic             auth_q;
   logic             locked_q;
   logic [CNT_W-1:0] cnt_q;
   logic             disp_q;
   logic             done_q, ok_q, bad_q, vb_q, ai_q, err_q;
   // Results computed in EXEC, presented together with done in DONE.
   logic             p_ok, p_bad, p_vb, p_ai, p_err, p_lock;
   logic             over_lim;

   // Saturating add so a deposit can never wrap the balance.
   function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                                input logic [BAL_W-1:0] b);
      logic [BAL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[BAL_W] ? {BAL_W{1'b1}} : s[BAL_W-1:0];
   endfunction

   // Withdraw amounts must be non-zero, within the single limit, whole notes.
   function automatic logic amt_invalid(input logic [BAL_W-1:0] a);
      return (a == '0) || (a > BAL_W'(MAX_WD)) ||
             ((a % BAL_W'(NOTE_VAL)) != '0);
   endfunction

   function automatic logic [CNT_W-1:0] notes_of(input logic [BAL_W-1:0] a);
      logic [BAL_W-1:0] q;
      q = a / BAL_W'(NOTE_VAL);
      return q[CNT_W-1:0];
   endfunction

   // Value of the notes still owed when a dispense is cancelled; cnt
   // includes the note already out in the current cycle.
   function automatic logic [BAL_W-1:0] refund_of(input logic [CNT_W-1:0] c);
      logic [BAL_W-1:0] r;
      r = BAL_W'(c - CNT_W'(1));
      return r * BAL_W'(NOTE_VAL);
   endfunction

`ifdef DAILY_LIMIT_EN
   logic [BAL_W-1:0] wd_tot_q;
   assign over_lim = ({1'b0, wd_tot_q} + {1'b0, amt_q}) > (BAL_W+1)'(DAILY_LIM);
`else
   assign over_lim = 1'b0;
`endif

   // Session FSM: request latch, execution, note pacing and status flags.
   always_ff @(posedge clk) begin
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      bad_q  <= 1'b0;
      vb_q   <= 1'b0;
      ai_q   <= 1'b0;
      err_q  <= 1'b0;
      if (rst) begin
         state    <= IDLE;
         bal_q    <= BAL_W'(INIT_BAL);
         tries_q  <= 2'd0;
         auth_q   <= 1'b0;
         locked_q <= 1'b0;
         disp_q   <= 1'b0;
         cnt_q    <= '0;
         p_ok     <= 1'b0;
         p_bad    <= 1'b0;
         p_vb     <= 1'b0;
         p_ai     <= 1'b0;
         p_err    <= 1'b0;
         p_lock   <= 1'b0;
`ifdef DAILY_LIMIT_EN
         wd_tot_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.action_valid) begin
                  act_q  <= bus.action;
                  pass_q <= bus.InPass;
                  amt_q  <= bus.amount;
                  p_ok   <= 1'b0;
                  p_bad  <= 1'b0;
                  p_vb   <= 1'b0;
                  p_ai   <= 1'b0;
                  p_err  <= 1'b0;
                  p_lock <= 1'b0;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               state <= DONE;
               case (act_q)
                  A_PASS: begin
                     if (pass_q == PASSWORD) begin
                        p_ok    <= 1'b1;
                        auth_q  <= 1'b1;
                        tries_q <= 2'd0;
                     end else begin
                        p_bad   <= 1'b1;
                        tries_q <= tries_q + 2'd1;
                        if ((tries_q + 2'd1) == 2'(MAX_TRIES)) begin
                           p_lock <= 1'b1;
                           auth_q <= 1'b0;
                        end
                     end
                  end
                  A_END: begin
                     auth_q <= 1'b0;
`ifdef DAILY_LIMIT_EN
                     wd_tot_q <= '0;
`endif
                  end
                  A_BALANCE: begin
                     if (!auth_q) p_err <= 1'b1;
                     else         p_vb  <= 1'b1;
                  end
                  A_DEPOSIT: begin
                     if (!auth_q)            p_err <= 1'b1;
                     else if (amt_q == '0)   p_ai  <= 1'b1;
                     else begin
                        bal_q <= sat_add(bal_q, amt_q);
                        p_vb  <= 1'b1;
                     end
                  end
                  A_WITHDRAW: begin
                     if (!auth_q)                          p_err <= 1'b1;
                     else if (amt_invalid(amt_q))          p_ai  <= 1'b1;
                     else if ((amt_q > bal_q) || over_lim) p_vb  <= 1'b0;
                     else begin
                        bal_q  <= bal_q - amt_q;
                        cnt_q  <= notes_of(amt_q);
                        disp_q <= 1'b1;
                        state  <= DISPENSE;
`ifdef DAILY_LIMIT_EN
                        wd_tot_q <= wd_tot_q + amt_q;
`endif
                     end
                  end
                  default: ;
               endcase
            end
            DISPENSE: begin
               if (cnt_q == CNT_W'(1)) begin
                  disp_q <= 1'b0;
                  done_q <= 1'b1;
                  vb_q   <= 1'b1;
                  state  <= IDLE;
               end else if (bus.cnl) begin
                  disp_q <= 1'b0;
                  bal_q  <= bal_q + refund_of(cnt_q);
                  done_q <= 1'b1;
                  vb_q   <= 1'b1;
                  state  <= IDLE;
`ifdef DAILY_LIMIT_EN
                  wd_tot_q <= wd_tot_q - refund_of(cnt_q);
`endif
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               done_q <= 1'b1;
               ok_q   <= p_ok;
               bad_q  <= p_bad;
               vb_q   <= p_vb;
               ai_q   <= p_ai;
               err_q  <= p_err;
               if (p_lock) begin
                  locked_q <= 1'b1;
                  state    <= LOCK;
               end else begin
                  state <= IDLE;
               end
            end
            LOCK: state <= LOCK;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.pass_ok  = ok_q;
   assign bus.pass_bad = bad_q;
   assign bus.vb       = vb_q;
   assign bus.ai       = ai_q;
   assign bus.err_auth = err_q;
   assign bus.dispense = disp_q;
   assign bus.locked   = locked_q;
   assign bus.balance  = bal_q;
   assign bus.tries    = tries_q;

endmodule

// File: tb/tb_atm_account_responder.sv
// Bench for atm_account_responder: table of requests with a queue of
// expected responses, plus lockout and reset sequences.
module tb_atm_account_responder;

   localparam logic [4:0] A_END      = 5'd1;
   localparam logic [4:0] A_PASS     = 5'd4;
   localparam logic [4:0] A_BALANCE  = 5'd8;
   localparam logic [4:0] A_DEPOSIT  = 5'd10;
   localparam logic [4:0] A_WITHDRAW = 5'd13;

   typedef struct {
      logic [4:0]  act;
      logic [3:0]  pin;
      logic [15:0] amt;
      int          cnl_at;
      logic [4:0]  flags;   // {pass_ok, pass_bad, vb, ai, err_auth}
      logic [15:0] bal;
      logic [1:0]  tries;
      int          pulses;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   vec_t exp_q[$];
   vec_t tbl1[$];
   vec_t tbl2[$];

   atm_account_responder_if #(.BAL_W(16)) bus();

   atm_account_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] act, input logic [3:0] pin,
                               input logic [15:0] amt, input int cnl_at,
                               input logic [4:0] flags, input logic [15:0] bal,
                               input logic [1:0] tries, input int pulses);
      vec_t v;
      v.act = act; v.pin = pin; v.amt = amt; v.cnl_at = cnl_at;
      v.flags = flags; v.bal = bal; v.tries = tries; v.pulses = pulses;
      return v;
   endfunction

   task automatic run_req(input vec_t v);
      int   cyc;
      int   npulse;
      bit   got;
      bit   leak;
      vec_t e;
      cyc = 0;
      while (bus.busy && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("idle_wait", bus.busy, 0);
      bus.action       = v.act;
      bus.InPass       = v.pin;
      bus.amount       = v.amt;
      bus.action_valid = 1'b1;
      exp_q.push_back(v);
      @(posedge clk);
      @(negedge clk);
      bus.action_valid = 1'b0;
      npulse = 0;
      got    = 1'b0;
      leak   = 1'b0;
      for (int c = 1; c <= 80 && !got; c++) begin
         @(posedge clk);
         @(negedge clk);
         bus.cnl = 1'b0;
         if (bus.dispense) begin
            npulse++;
            if (npulse == v.cnl_at) bus.cnl = 1'b1;
         end
         if (bus.done) begin
            got = 1'b1;
            e = exp_q.pop_front();
            check("flags", {bus.pass_ok, bus.pass_bad, bus.vb, bus.ai, bus.err_auth}, e.flags);
            check("balance", bus.balance, e.bal);
            check("tries", bus.tries, e.tries);
            check("pulses", npulse, e.pulses);
            check("latency", c, (e.pulses == 0) ? 2 : e.pulses + 1);
         end else if (bus.pass_ok | bus.pass_bad | bus.vb | bus.ai | bus.err_auth) begin
            leak = 1'b1;
         end
      end
      bus.cnl = 1'b0;
      check("flags_without_done", leak, 0);
      if (!got) begin
         check("done_timeout", 0, 1);
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      int seen;
      rst = 1'b1;
      bus.action = '0; bus.action_valid = 1'b0; bus.InPass = '0;
      bus.amount = '0; bus.cnl = 1'b0;

      // flags: {ok, bad, vb, ai, err}
      tbl1.push_back(mk(A_PASS, 4'b1111, 16'd0, 0, 5'b10000, 16'd1000, 2'd0, 0));
      tbl1.push_back(mk(A_PASS, 4'b1100, 16'd0, 0, 5'b01000, 16'd1000, 2'd1, 0));
      tbl1.push_back(mk(A_PASS, 4'b1100, 16'd0, 0, 5'b01000, 16'd1000, 2'd2, 0));

      tbl2.push_back(mk(A_BALANCE,  4'b0000, 16'd0,     0, 5'b00001, 16'd1000,  2'd0, 0));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd30,    0, 5'b00001, 16'd1000,  2'd0, 0));
      tbl2.push_back(mk(A_PASS,     4'b1111, 16'd0,     0, 5'b10000, 16'd1000,  2'd0, 0));
      tbl2.push_back(mk(A_BALANCE,  4'b0000, 16'd0,     0, 5'b00100, 16'd1000,  2'd0, 0));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd30,    0, 5'b00100, 16'd970,   2'd0, 3));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd25,    0, 5'b00010, 16'd970,   2'd0, 0));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd0,     0, 5'b00010, 16'd970,   2'd0, 0));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd510,   0, 5'b00010, 16'd970,   2'd0, 0));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd500,   0, 5'b00100, 16'd470,   2'd0, 50));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd500,   0, 5'b00000, 16'd470,   2'd0, 0));
      tbl2.push_back(mk(A_DEPOSIT,  4'b0000, 16'd0,     0, 5'b00010, 16'd470,   2'd0, 0));
      tbl2.push_back(mk(A_DEPOSIT,  4'b0000, 16'd530,   0, 5'b00100, 16'd1000,  2'd0, 0));
      tbl2.push_back(mk(5'd3,       4'b0000, 16'd40,    0, 5'b00000, 16'd1000,  2'd0, 0));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd50,    2, 5'b00100, 16'd980,   2'd0, 2));
      tbl2.push_back(mk(A_WITHDRAW, 4'b0000, 16'd10,    1, 5'b00100, 16'd970,   2'd0, 1));
      tbl2.push_back(mk(A_DEPOSIT,  4'b0000, 16'd65000, 0, 5'b00100, 16'd65535, 2'd0, 0));
      tbl2.push_back(mk(A_END,      4'b0000, 16'd0,     0, 5'b00000, 16'd65535, 2'd0, 0));
      tbl2.push_back(mk(A_BALANCE,  4'b0000, 16'd0,     0, 5'b00001, 16'd65535, 2'd0, 0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_balance", bus.balance, 1000);
      check("rst_tries", bus.tries, 0);
      check("rst_locked", bus.locked, 0);
      check("rst_dispense", bus.dispense, 0);

      for (int i = 0; i < tbl1.size(); i++) run_req(tbl1[i]);

      // Third consecutive wrong PIN locks the account.
      run_req(mk(A_PASS, 4'b1100, 16'd0, 0, 5'b01000, 16'd1000, 2'd3, 0));
      @(negedge clk);
      check("lock_locked", bus.locked, 1);
      check("lock_busy", bus.busy, 1);
      bus.action = A_PASS; bus.InPass = 4'b1111; bus.action_valid = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         bus.action_valid = 1'b0;
         if (bus.done) seen = 1;
      end
      check("lock_ignores_req", seen, 0);
      check("lock_still_locked", bus.locked, 1);
      check("lock_still_busy", bus.busy, 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("unlock_locked", bus.locked, 0);
      check("unlock_busy", bus.busy, 0);
      check("unlock_tries", bus.tries, 0);

      for (int i = 0; i < tbl2.size(); i++) run_req(tbl2[i]);

      // Reset in the middle of a dispense: no refund, balance back to initial.
      run_req(mk(A_PASS, 4'b1111, 16'd0, 0, 5'b10000, 16'd65535, 2'd0, 0));
      bus.action = A_WITHDRAW; bus.amount = 16'd100; bus.action_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.action_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_disp_pulsing", bus.dispense, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_disp_rst_dispense", bus.dispense, 0);
      check("mid_disp_rst_balance", bus.balance, 1000);
      check("mid_disp_rst_busy", bus.busy, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
